// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment patterns are active-low and packed as {A,B,C,D,E,F,G}.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit common-anode scan controller with a frame-synchronous double buffer.
// Outputs are registered from next-state values so output cycle k matches slot count k.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        upd_pending,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx_q;
    logic [2:0]       idx_nxt;
    scan_state_e      state_q;
    scan_state_e      state_nxt;

    logic [31:0]      shd_data_q;
    logic [7:0]       shd_dp_q;
    logic [7:0]       shd_en_q;
    logic [31:0]      act_data_q;
    logic [31:0]      act_data_nxt;
    logic [7:0]       act_dp_q;
    logic [7:0]       act_dp_nxt;
    logic [7:0]       act_en_q;
    logic [7:0]       act_en_nxt;
    logic             pend_nxt;

    logic             slot_wrap;
    logic             frame_wrap;
    logic             show_nxt;
    logic [3:0]       nib_nxt;
    logic [6:0]       dec_seg;

    always_comb begin
        slot_wrap  = (cnt_q == CNT_LAST);
        frame_wrap = slot_wrap && (idx_q == 3'd7);
        cnt_nxt    = slot_wrap ? '0 : cnt_q + 1'b1;
        idx_nxt    = slot_wrap ? idx_q + 3'd1 : idx_q;
    end

    // Slot FSM; with BLANK_CYCLES=0 the SHOW state is never left.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            BLANK:   if (32'(cnt_nxt) >= BLANK_CYCLES) state_nxt = SHOW;
            SHOW:    if (slot_wrap && (BLANK_CYCLES != 0)) state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase
    end

    // A load landing on the frame edge bypasses the shadow and wins over it.
    always_comb begin
        act_data_nxt = act_data_q;
        act_dp_nxt   = act_dp_q;
        act_en_nxt   = act_en_q;
        pend_nxt     = upd_pending;
        if (frame_wrap) begin
            if (load) begin
                act_data_nxt = data_in;
                act_dp_nxt   = dp_in;
                act_en_nxt   = digit_en;
            end else if (upd_pending) begin
                act_data_nxt = shd_data_q;
                act_dp_nxt   = shd_dp_q;
                act_en_nxt   = shd_en_q;
            end
            pend_nxt = 1'b0;
        end else if (load) begin
            pend_nxt = 1'b1;
        end
    end

    always_comb begin
        nib_nxt  = act_data_nxt[{idx_nxt, 2'b00} +: 4];
        show_nxt = (state_nxt == SHOW) && act_en_nxt[idx_nxt];
    end

    seg7_hex_decode u_dec (
        .nibble (nib_nxt),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            state_q     <= BLANK;
            shd_data_q  <= '0;
            shd_dp_q    <= '0;
            shd_en_q    <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_en_q    <= '0;
            upd_pending <= 1'b0;
            frame_done  <= 1'b0;
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            cnt_q       <= cnt_nxt;
            idx_q       <= idx_nxt;
            state_q     <= state_nxt;
            if (load) begin
                shd_data_q <= data_in;
                shd_dp_q   <= dp_in;
                shd_en_q   <= digit_en;
            end
            act_data_q  <= act_data_nxt;
            act_dp_q    <= act_dp_nxt;
            act_en_q    <= act_en_nxt;
            upd_pending <= pend_nxt;
            frame_done  <= frame_wrap;
            an          <= show_nxt ? ~(8'd1 << idx_nxt) : AN_OFF;
            seg         <= show_nxt ? dec_seg : SEG_BLANK;
            dp          <= show_nxt ? ~act_dp_nxt[idx_nxt] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-count based reference model checked every cycle,
// plus directed literal expectations at chosen cycles.
module tb_seg_scan_ctrl;

    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 8 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  digit_en = '0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        upd_pending;
    logic        frame_done;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .upd_pending (upd_pending),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model: cycle count since reset plus shadow/active copies.
    int          cyc = 0;
    logic [31:0] m_sdata = '0, m_adata = '0;
    logic [7:0]  m_sdp = '0, m_sen = '0, m_adp = '0, m_aen = '0;
    logic        m_pend = 1'b0, m_fd = 1'b0;
    bit          chk_en = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                cyc = 0;
                m_sdata = '0; m_sdp = '0; m_sen = '0;
                m_adata = '0; m_adp = '0; m_aen = '0;
                m_pend = 1'b0; m_fd = 1'b0;
                chk_en = 1'b1;
            end else begin
                if (cyc % FRAME == FRAME - 1) begin
                    m_fd = 1'b1;
                    if (load) begin
                        m_adata = data_in; m_adp = dp_in; m_aen = digit_en;
                    end else if (m_pend) begin
                        m_adata = m_sdata; m_adp = m_sdp; m_aen = m_sen;
                    end
                    m_pend = 1'b0;
                end else begin
                    m_fd = 1'b0;
                    if (load) begin
                        m_sdata = data_in; m_sdp = dp_in; m_sen = digit_en;
                        m_pend = 1'b1;
                    end
                end
                cyc++;
            end
        end
    end

    initial begin
        int          idx;
        int          c;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                idx = (cyc / RD) % 8;
                c   = cyc % RD;
                if (c >= BC && m_aen[idx]) begin
                    e_an  = ~(8'd1 << idx);
                    e_seg = hex_tbl[m_adata[4*idx +: 4]];
                    e_dp  = ~m_adp[idx];
                end else begin
                    e_an  = 8'hFF;
                    e_seg = 7'h7F;
                    e_dp  = 1'b1;
                end
                cmp("an", 32'(an), 32'(e_an));
                cmp("seg", 32'(seg), 32'(e_seg));
                cmp("dp", 32'(dp), 32'(e_dp));
                cmp("upd_pending", 32'(upd_pending), 32'(m_pend));
                cmp("frame_done", 32'(frame_done), 32'(m_fd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        int n = 0;
        while (cyc != t && n < 2000) begin
            tick();
            n++;
        end
        if (cyc != t) begin
            checks++;
            errors++;
            $display("FAIL goto: at cycle %0d required %0d", cyc, t);
        end
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
        load = 1'b1; data_in = d; dp_in = p; digit_en = e;
        tick();
        load = 1'b0; data_in = '0; dp_in = '0; digit_en = '0;
    endtask

    task automatic lit(input string name, input logic [7:0] e_an, input logic [6:0] e_seg, input logic e_dp);
        cmp({name, "_an"}, 32'(an), 32'(e_an));
        cmp({name, "_seg"}, 32'(seg), 32'(e_seg));
        cmp({name, "_dp"}, 32'(dp), 32'(e_dp));
    endtask

    initial begin
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        lit("reset", 8'hFF, 7'h7F, 1'b1);
        cmp("reset_pend", 32'(upd_pending), 32'd0);
        cmp("reset_fd", 32'(frame_done), 32'd0);

        goto(2);
        do_load(32'h76543210, 8'h00, 8'hFF);
        cmp("load_pend", 32'(upd_pending), 32'd1);
        goto(17);
        lit("dark_before_commit", 8'hFF, 7'h7F, 1'b1);
        goto(31);
        cmp("pend_31", 32'(upd_pending), 32'd1);
        goto(32);
        cmp("fd_32", 32'(frame_done), 32'd1);
        cmp("pend_32", 32'(upd_pending), 32'd0);
        lit("blank_32", 8'hFF, 7'h7F, 1'b1);
        goto(33); lit("d0", 8'hFE, 7'h01, 1'b1);
        goto(37); lit("d1", 8'hFD, 7'h4F, 1'b1);
        goto(41); lit("d2", 8'hFB, 7'h12, 1'b1);
        goto(61); lit("d7", 8'h7F, 7'h0F, 1'b1);

        goto(62);
        do_load(32'hFEDCBA98, 8'h81, 8'hFF);
        goto(65); lit("hex8", 8'hFE, 7'h00, 1'b0);
        goto(69); lit("hex9", 8'hFD, 7'h04, 1'b1);
        goto(73); lit("hexA", 8'hFB, 7'h08, 1'b1);
        goto(93); lit("hexF", 8'h7F, 7'h38, 1'b0);

        goto(100);
        do_load(32'hFEDCBA98, 8'h81, 8'h05);
        goto(129); lit("en_d0", 8'hFE, 7'h00, 1'b0);
        goto(133); lit("en_d1", 8'hFF, 7'h7F, 1'b1);
        goto(137); lit("en_d2", 8'hFB, 7'h08, 1'b1);
        goto(141); lit("en_d3", 8'hFF, 7'h7F, 1'b1);

        goto(173);
        do_load(32'h89ABCDEF, 8'h00, 8'hFF);
        goto(181);
        do_load(32'h01234567, 8'h00, 8'hFF);
        goto(185);
        lit("midframe_old", 8'hFF, 7'h7F, 1'b1);
        cmp("midframe_pend", 32'(upd_pending), 32'd1);
        goto(201); lit("second_wins_d2", 8'hFB, 7'h24, 1'b1);
        goto(217); lit("second_wins_d6", 8'hBF, 7'h4F, 1'b1);

        goto(223);
        do_load(32'hAAAAAAAA, 8'h00, 8'hFF);
        cmp("edge_load_pend", 32'(upd_pending), 32'd0);
        cmp("edge_load_fd", 32'(frame_done), 32'd1);
        goto(225); lit("edge_load_d0", 8'hFE, 7'h08, 1'b1);

        goto(241);
        lit("pre_rst_d4", 8'hEF, 7'h08, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lit("mid_rst", 8'hFF, 7'h7F, 1'b1);
        cmp("mid_rst_pend", 32'(upd_pending), 32'd0);
        goto(5); lit("cleared_d1", 8'hFF, 7'h7F, 1'b1);
        goto(32);
        cmp("fd_after_rst", 32'(frame_done), 32'd1);
        goto(33); lit("cleared_next_frame", 8'hFF, 7'h7F, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
